// File: rtl/horizontal_tf_sched.sv
// Twiddle-factor issue scheduler: walks stages x groups, fetches one ROM group per pass and issues
// fifteen twiddle indices to the modular multiplier, tracking multiplier latency with a delay line.
module horizontal_tf_sched #(
  parameter int unsigned S_WIDTH    = 4,
  parameter int unsigned DC_WIDTH   = 13,
  parameter int unsigned DCNT_BP4   = 10,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MUL_LAT    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          stall,
  input  logic [DC_WIDTH-DCNT_BP4-1:0]  cfg_stages,
  input  logic [ADDR_WIDTH-1:0]         cfg_groups,
  output logic [S_WIDTH-1:0]            state,
  output logic [DC_WIDTH-1:DCNT_BP4]    stage_counter,
  output logic                          CEN,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  output logic [3:0]                    tf_sel,
  output logic                          issue_valid,
  output logic                          out_valid,
  output logic [3:0]                    out_tf_sel,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned SW = DC_WIDTH - DCNT_BP4;
  localparam int unsigned DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [SW-1:0]         stages_q, stages_d;
  logic [ADDR_WIDTH-1:0] group_q, group_d;
  logic [ADDR_WIDTH-1:0] groups_q, groups_d;
  logic [3:0]            tf_q, tf_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic [MUL_LAT-1:0]    dl_valid_q;
  logic [3:0]            dl_sel_q [MUL_LAT];

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    stages_d = stages_q;
    group_d  = group_q;
    groups_d = groups_q;
    tf_d     = tf_q;
    drain_d  = drain_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFetch;
          stages_d = (cfg_stages == '0) ? SW'(1) : cfg_stages;
          groups_d = (cfg_groups == '0) ? ADDR_WIDTH'(1) : cfg_groups;
          stage_d  = '0;
          group_d  = '0;
          tf_d     = 4'd1;
        end
      end
      StFetch: state_d = StRun;
      StRun: begin
        if (!stall) begin
          if (tf_q == 4'd15) begin
            tf_d = 4'd1;
            if (group_q < groups_q - ADDR_WIDTH'(1)) begin
              group_d = group_q + ADDR_WIDTH'(1);
              state_d = StFetch;
            end else if (stage_q < stages_q - SW'(1)) begin
              group_d = '0;
              stage_d = stage_q + SW'(1);
              state_d = StFetch;
            end else begin
              drain_d = '0;
              state_d = StDrain;
            end
          end else begin
            tf_d = tf_q + 4'd1;
          end
        end
      end
      StDrain: begin
        if (drain_q == DW'(MUL_LAT - 1)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      stage_d = '0;
      group_d = '0;
      tf_d    = 4'd1;
      drain_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      stage_q  <= '0;
      stages_q <= SW'(1);
      group_q  <= '0;
      groups_q <= ADDR_WIDTH'(1);
      tf_q     <= 4'd1;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      stages_q <= stages_d;
      group_q  <= group_d;
      groups_q <= groups_d;
      tf_q     <= tf_d;
      drain_q  <= drain_d;
    end
  end

  // Free-running latency tracker; only reset and abort flush it.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      dl_valid_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) dl_sel_q[i] <= 4'd0;
    end else begin
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_sel_q[i]   <= dl_sel_q[i-1];
      end
      dl_valid_q[0] <= issue_valid;
      dl_sel_q[0]   <= issue_valid ? tf_q : 4'd0;
    end
  end

  assign state         = S_WIDTH'(state_q);
  assign stage_counter = stage_q;
  assign rom_addr      = group_q;
  assign tf_sel        = tf_q;
  assign CEN           = (state_q != StFetch);
  assign issue_valid   = (state_q == StRun) && !stall;
  assign out_valid     = dl_valid_q[MUL_LAT-1];
  assign out_tf_sel    = dl_sel_q[MUL_LAT-1];
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule

// File: doc/horizontal_tf_sched.md
HORIZONTAL_TF_SCHED -- requirements
Module: horizontal_tf_sched

Interface
REQ-001 SHALL have parameter S_WIDTH, default 4, width of state output.
REQ-002 SHALL have parameter DC_WIDTH, default 13, and DCNT_BP4, default 10; stage_counter spans [DC_WIDTH-1:DCNT_BP4].
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, twiddle ROM address width.
REQ-004 SHALL have parameter MUL_LAT, default 4, MulMod128 latency in cycles (>=1).
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle request to begin a transform.
REQ-009 abort  input  1  synchronous cancel; returns to IDLE.
REQ-010 stall  input  1  downstream backpressure; freezes issue.
REQ-011 cfg_stages  input  DC_WIDTH-DCNT_BP4  number of stages, sampled on accepted start.
REQ-012 cfg_groups  input  ADDR_WIDTH  groups per stage, sampled on accepted start.
REQ-013 state  output  S_WIDTH  FSM code driven to twiddle generator.
REQ-014 stage_counter  output  [DC_WIDTH-1:DCNT_BP4]  current stage.
REQ-015 CEN  output  1  active-low ROM chip enable.
REQ-016 rom_addr  output  ADDR_WIDTH  twiddle ROM group address.
REQ-017 tf_sel  output  4  twiddle index 1..15 for the Mux3 selection.
REQ-018 issue_valid  output  1  operand pair presented to MulMod128 this cycle.
REQ-019 out_valid, out_tf_sel  output  1, 4  issue_valid/tf_sel delayed MUL_LAT cycles.
REQ-020 busy, done  output  1, 1  transform in progress; one-cycle completion pulse.

Function
REQ-021 FSM codes on state: IDLE=0, FETCH=1, RUN=2, DRAIN=3, DONE=4; other codes unused.
REQ-022 IDLE: start=1 -> FETCH next cycle, latch cfg (value 0 treated as 1), stage_counter=0, rom_addr=0; start outside IDLE ignored.
REQ-023 FETCH: exactly one cycle, CEN=0, rom_addr = current group; -> RUN. CEN=1 in all other states.
REQ-024 RUN: tf_sel starts at 1, increments by 1 each non-stalled cycle; issue_valid=1 iff state==RUN and stall==0.
REQ-025 stall=1 in RUN holds tf_sel, rom_addr, stage_counter and FSM state.
REQ-026 Non-stalled RUN cycle with tf_sel=15: if group < cfg_groups-1 -> rom_addr+1, FETCH; else if stage < cfg_stages-1 -> rom_addr=0, stage_counter+1, FETCH; else -> DRAIN.
REQ-027 rom_addr and stage_counter never exceed latched cfg-1; no wrap beyond configured bounds.
REQ-028 Delay line for out_valid/out_tf_sel SHALL shift every cycle regardless of stall, state or start.
REQ-029 DRAIN: lasts exactly MUL_LAT cycles, then DONE; out_valid of final issue appears within DRAIN.
REQ-030 DONE: one cycle, done=1, -> IDLE; start in DONE ignored.
REQ-031 busy=1 in FETCH, RUN, DRAIN, DONE; 0 in IDLE.
REQ-032 abort=1 in any state: next cycle IDLE, counters cleared, delay line cleared, done not asserted; abort overrides start and stall in the same cycle.
REQ-033 Issue count for a run = 15 x cfg_stages x cfg_groups (after zero-to-one mapping).

Reset
REQ-034 rst=1 at clock edge: state=IDLE(0), stage_counter=0, rom_addr=0, tf_sel=1, CEN=1, issue_valid=0, out_valid=0, out_tf_sel=0, busy=0, done=0, latched cfg=1; delay line cleared.
REQ-035 rst mid-transform SHALL behave as REQ-034 with no done pulse; rst has priority over abort and start.

Verification
REQ-036 cfg_stages=1, cfg_groups=1, MUL_LAT=4, start -> FETCH 1 cycle, 15 issue_valid cycles tf_sel 1..15, out_valid 4 cycles later, DRAIN 4 cycles, done once; total start-to-done 21 cycles.
REQ-037 cfg_stages=2, cfg_groups=3 -> 6 CEN=0 pulses, rom_addr 0,1,2,0,1,2, stage_counter 0 then 1, 90 issue_valid pulses.
REQ-038 stall=1 for 3 cycles while tf_sel=7 -> tf_sel holds 7, issue_valid=0 those cycles, out_valid gap of 3 cycles after MUL_LAT, done delayed by exactly 3 cycles.
REQ-039 abort at 5th RUN cycle -> IDLE next cycle, busy=0, no done, no further out_valid; new start runs cleanly.
REQ-040 rst asserted during DRAIN -> all outputs at REQ-034 values next cycle; start while busy -> ignored, cfg unchanged.
REQ-041 cfg_groups=0, cfg_stages=0 -> behaves as 1/1 (15 issues, one done).
